// File: rtl/pool1_mem_write.sv
// 2x2 stride-2 max-pool between conv1 and the P1 memory: streams IN_DIM x IN_DIM maps in,
// writes OUT_DIM x OUT_DIM pooled results (optional ReLU) one cycle after each window completes.
module pool1_mem_write #(
    parameter int DATA_W   = 16,
    parameter int IN_DIM   = 24,
    parameter int OUT_DIM  = 12,
    parameter int ADDR_W   = 8,
    parameter int NUM_MAPS = 6,
    parameter int RELU     = 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     in_ready,
    output logic                     wr_en,
    output logic [ADDR_W-1:0]        wr_addr,
    output logic signed [DATA_W-1:0] wr_data,
    output logic [2:0]               map_idx,
    output logic                     done
);
    localparam int CNT_W     = $clog2(IN_DIM);
    localparam int LB_W      = CNT_W - 1;
    localparam int LAST_ADDR = OUT_DIM * OUT_DIM - 1;

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t                     state_q, state_d;
    logic [CNT_W-1:0]           col_q, col_d, row_q, row_d;
    logic [2:0]                 map_cnt_q, map_cnt_d;
    logic [ADDR_W-1:0]          wa_q, wa_d, wr_addr_q, wr_addr_d;
    logic signed [DATA_W-1:0]   hold_q, hold_d, wr_data_q, wr_data_d;
    logic signed [DATA_W-1:0]   lb_q [OUT_DIM];
    logic signed [DATA_W-1:0]   lb_d [OUT_DIM];
    logic                       wr_en_q, wr_en_d, done_q, done_d;
    logic [2:0]                 map_idx_q, map_idx_d;
    logic                       accept;
    logic [LB_W-1:0]            lb_idx;
    logic signed [DATA_W-1:0]   pmax;

    function automatic logic signed [DATA_W-1:0] smax(input logic signed [DATA_W-1:0] a,
                                                      input logic signed [DATA_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic signed [DATA_W-1:0] relu_clamp(input logic signed [DATA_W-1:0] x);
        return ((RELU != 0) && x[DATA_W-1]) ? '0 : x;
    endfunction

    assign accept = in_valid && (state_q == RUN);
    assign lb_idx = col_q[CNT_W-1:1];
    assign pmax   = smax(hold_q, in_data);

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        map_cnt_d = map_cnt_q;
        wa_d      = wa_q;
        hold_d    = hold_q;
        lb_d      = lb_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        map_idx_d = map_idx_q;
        done_d    = done_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d   = RUN;
                    col_d     = '0;
                    row_d     = '0;
                    map_cnt_d = '0;
                    wa_d      = '0;
                    map_idx_d = '0;
                    done_d    = 1'b0;
                end
            end
            RUN: begin
                if (accept) begin
                    // Even column primes the pair; odd column closes it into the row or the window.
                    if (!col_q[0]) begin
                        hold_d = in_data;
                    end else if (!row_q[0]) begin
                        lb_d[lb_idx] = pmax;
                    end else begin
                        wr_en_d   = 1'b1;
                        wr_data_d = relu_clamp(smax(lb_q[lb_idx], pmax));
                        wr_addr_d = wa_q;
                        map_idx_d = map_cnt_q;
                        wa_d      = (wa_q == ADDR_W'(LAST_ADDR)) ? '0 : wa_q + 1'b1;
                    end
                    if (col_q == CNT_W'(IN_DIM - 1)) begin
                        col_d = '0;
                        if (row_q == CNT_W'(IN_DIM - 1)) begin
                            row_d = '0;
                            if (map_cnt_q == 3'(NUM_MAPS - 1)) begin
                                map_cnt_d = '0;
                                state_d   = DONE;
                                done_d    = 1'b1;
                            end else begin
                                map_cnt_d = map_cnt_q + 3'd1;
                            end
                        end else begin
                            row_d = row_q + 1'b1;
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            col_q     <= '0;
            row_q     <= '0;
            map_cnt_q <= '0;
            wa_q      <= '0;
            hold_q    <= '0;
            for (int i = 0; i < OUT_DIM; i++) lb_q[i] <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            map_idx_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            map_cnt_q <= map_cnt_d;
            wa_q      <= wa_d;
            hold_q    <= hold_d;
            lb_q      <= lb_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            map_idx_q <= map_idx_d;
            done_q    <= done_d;
        end
    end

    assign in_ready = (state_q == RUN);
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign map_idx  = map_idx_q;
    assign done     = done_q;
endmodule
